// File: rtl/barrel_unrotate_32_pipe.sv
// Two-stage pipelined rotate restorer.
// This block undoes a rotation that was applied earlier to a 32-bit word.
// S1 performs the fine rotation by shift[2:0].
// S2 performs the coarse rotation by 8*shift[4:3].
// A ready/valid skid-free handshake connects the stages, and the pipeline holds up to two words.
module barrel_unrotate_32_pipe #(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_data,
    input  logic [4:0]         in_shift,
    input  logic               in_dir,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_data,
    output logic [COUNT_W-1:0] out_count
);

    // Rotate right: the low half of the doubled word shifted right.
    function automatic logic [31:0] rotR(input logic [31:0] x, input logic [4:0] n);
        logic [63:0] t;
        t = {x, x} >> n;
        return t[31:0];
    endfunction

    // Rotate left: the high half of the doubled word shifted left.
    function automatic logic [31:0] rotL(input logic [31:0] x, input logic [4:0] n);
        logic [63:0] t;
        t = {x, x} << n;
        return t[63:32];
    endfunction

    logic        s1Valid;
    logic [31:0] s1Data;
    logic [1:0]  s1Coarse;
    logic        s1Dir;

    logic        s2Adv;
    logic        s1Adv;
    logic        accept;
    logic [31:0] fineData;
    logic [31:0] coarseData;

    // Handshake. in_ready is the only input-to-output combinational path, and it depends on out_ready.
    assign s2Adv    = !out_valid || out_ready;
    assign s1Adv    = s1Valid && s2Adv;
    assign in_ready = !s1Valid || s2Adv;
    assign accept   = in_valid && in_ready;

    // Undo a left rotation by rotating right, and undo a right rotation by rotating left.
    assign fineData   = in_dir ? rotR(in_data, {2'b00, in_shift[2:0]})
                               : rotL(in_data, {2'b00, in_shift[2:0]});
    assign coarseData = s1Dir  ? rotR(s1Data, {s1Coarse, 3'b000})
                               : rotL(s1Data, {s1Coarse, 3'b000});

    // S1: capture the finely rotated word, or drain when its word moves on to S2.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1Valid  <= 1'b0;
            s1Data   <= '0;
            s1Coarse <= '0;
            s1Dir    <= 1'b0;
        end else if (accept) begin
            s1Valid  <= 1'b1;
            s1Data   <= fineData;
            s1Coarse <= in_shift[4:3];
            s1Dir    <= in_dir;
        end else if (s1Adv) begin
            s1Valid  <= 1'b0;
        end
    end

    // S2: register the restored word. While there is no word, out_data keeps its last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (s2Adv) begin
            out_valid <= s1Valid;
            if (s1Valid) out_data <= coarseData;
        end
    end

    // Count consumed output words. The counter wraps naturally at 2^COUNT_W.
    always_ff @(posedge clk) begin
        if (rst)                         out_count <= '0;
        else if (out_valid && out_ready) out_count <= out_count + COUNT_W'(1);
    end

endmodule
